// File: rtl/lfsr_stream_checker.sv
// Bring-up checker: programs an AXI-Lite LFSR stream generator, consumes its
// AXI-Stream output and checks every beat against the 8-bit LFSR recurrence.
module lfsr_stream_checker #(
    parameter int C_AXIL_ADDR_WIDTH = 4,
    parameter int C_AXIL_DATA_WIDTH = 32,
    parameter int C_CNT_WIDTH       = 16
) (
    input  logic                         aclk,
    input  logic                         areset,
    input  logic                         cfg_start,
    input  logic [7:0]                   cfg_seed,
    input  logic [7:0]                   cfg_taps,
    input  logic [C_CNT_WIDTH-1:0]       cfg_count,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic                         resp_err,
    output logic [C_CNT_WIDTH-1:0]       rx_count,
    output logic [C_CNT_WIDTH-1:0]       err_count,
    output logic [C_AXIL_ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic                         m_axi_awvalid,
    input  logic                         m_axi_awready,
    output logic [C_AXIL_DATA_WIDTH-1:0] m_axi_wdata,
    output logic                         m_axi_wvalid,
    input  logic                         m_axi_wready,
    input  logic [1:0]                   m_axi_bresp,
    input  logic                         m_axi_bvalid,
    output logic                         m_axi_bready,
    output logic [C_AXIL_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic                         m_axi_arvalid,
    input  logic                         m_axi_arready,
    input  logic [C_AXIL_DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]                   m_axi_rresp,
    input  logic                         m_axi_rvalid,
    output logic                         m_axi_rready,
    input  logic [C_AXIL_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                         s_axis_tvalid,
    output logic                         s_axis_tready
);

    localparam int AW = C_AXIL_ADDR_WIDTH;
    localparam int DW = C_AXIL_DATA_WIDTH;
    localparam int CW = C_CNT_WIDTH;

    localparam logic [AW-1:0] ADDR_START = AW'(0);
    localparam logic [AW-1:0] ADDR_STOP  = AW'(4);
    localparam logic [AW-1:0] ADDR_SEED  = AW'(8);
    localparam logic [AW-1:0] ADDR_TAPS  = AW'(12);
    localparam logic [DW-1:0] DATA_ONE   = DW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_SEED,
        S_WR_TAPS,
        S_WR_START,
        S_RECV,
        S_WR_STOP,
        S_DONE
    } state_t;

    function automatic logic [7:0] lfsr_next(input logic [7:0] x, input logic [7:0] taps);
        return {^(x & taps), x[7:1]};
    endfunction

    state_t          state_q, state_d;
    logic            awvalid_q, awvalid_d;
    logic            wvalid_q, wvalid_d;
    logic            bready_q, bready_d;
    logic [AW-1:0]   awaddr_q, awaddr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [7:0]      taps_q, taps_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   rx_q, rx_d;
    logic [CW-1:0]   err_q, err_d;
    logic            resp_err_q, resp_err_d;
    logic            pass_q, pass_d;
    logic [7:0]      prev_q, prev_d;

    logic            aw_fire, w_fire, b_fire, beat, in_write;
    logic [CW-1:0]   rx_inc;
    logic [DW-1:0]   exp_beat;
    logic            launch;
    logic [AW-1:0]   launch_addr;
    logic [DW-1:0]   launch_data;

    assign aw_fire  = awvalid_q & m_axi_awready;
    assign w_fire   = wvalid_q & m_axi_wready;
    assign b_fire   = bready_q & m_axi_bvalid;
    assign beat     = (state_q == S_RECV) & s_axis_tvalid;
    assign rx_inc   = rx_q + CW'(1);
    assign exp_beat = {{(DW-8){1'b0}}, lfsr_next(prev_q, taps_q)};
    assign in_write = (state_q == S_WR_SEED) || (state_q == S_WR_TAPS) ||
                      (state_q == S_WR_START) || (state_q == S_WR_STOP);

    always_comb begin
        state_d     = state_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;
        taps_d      = taps_q;
        count_d     = count_q;
        rx_d        = rx_q;
        err_d       = err_q;
        resp_err_d  = resp_err_q;
        pass_d      = pass_q;
        prev_d      = prev_q;
        launch      = 1'b0;
        launch_addr = '0;
        launch_data = '0;

        // AW and W retire independently; B is only requested once both have gone.
        if (in_write) begin
            if (aw_fire) awvalid_d = 1'b0;
            if (w_fire)  wvalid_d  = 1'b0;
            bready_d = !awvalid_d && !wvalid_d && !b_fire;
            if (b_fire && (m_axi_bresp != 2'b00)) resp_err_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (cfg_start) begin
                    taps_d      = cfg_taps;
                    count_d     = cfg_count;
                    rx_d        = '0;
                    err_d       = '0;
                    resp_err_d  = 1'b0;
                    pass_d      = 1'b0;
                    state_d     = S_WR_SEED;
                    launch      = 1'b1;
                    launch_addr = ADDR_SEED;
                    launch_data = {{(DW-8){1'b0}}, cfg_seed};
                end
            end
            S_WR_SEED: begin
                if (b_fire) begin
                    state_d     = S_WR_TAPS;
                    launch      = 1'b1;
                    launch_addr = ADDR_TAPS;
                    launch_data = {{(DW-8){1'b0}}, taps_q};
                end
            end
            S_WR_TAPS: begin
                if (b_fire) begin
                    state_d     = S_WR_START;
                    launch      = 1'b1;
                    launch_addr = ADDR_START;
                    launch_data = DATA_ONE;
                end
            end
            S_WR_START: begin
                if (b_fire) begin
                    if (count_q == '0) begin
                        state_d     = S_WR_STOP;
                        launch      = 1'b1;
                        launch_addr = ADDR_STOP;
                        launch_data = DATA_ONE;
                    end else begin
                        state_d = S_RECV;
                    end
                end
            end
            S_RECV: begin
                if (beat) begin
                    rx_d   = rx_inc;
                    prev_d = s_axis_tdata[7:0];
                    // First beat only seeds the reference; later ones resync on mismatch.
                    if ((rx_q != '0) && (s_axis_tdata != exp_beat) && (err_q != '1))
                        err_d = err_q + CW'(1);
                    if (rx_inc == count_q) begin
                        state_d     = S_WR_STOP;
                        launch      = 1'b1;
                        launch_addr = ADDR_STOP;
                        launch_data = DATA_ONE;
                    end
                end
            end
            S_WR_STOP: begin
                if (b_fire) begin
                    state_d = S_DONE;
                    pass_d  = (err_q == '0) && !resp_err_d && (rx_q == count_q);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (launch) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            bready_d  = 1'b0;
            awaddr_d  = launch_addr;
            wdata_d   = launch_data;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q    <= S_IDLE;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            taps_q     <= '0;
            count_q    <= '0;
            rx_q       <= '0;
            err_q      <= '0;
            resp_err_q <= 1'b0;
            pass_q     <= 1'b0;
            prev_q     <= '0;
        end else begin
            state_q    <= state_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            bready_q   <= bready_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            taps_q     <= taps_d;
            count_q    <= count_d;
            rx_q       <= rx_d;
            err_q      <= err_d;
            resp_err_q <= resp_err_d;
            pass_q     <= pass_d;
            prev_q     <= prev_d;
        end
    end

    assign busy          = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done          = (state_q == S_DONE);
    assign pass          = pass_q;
    assign resp_err      = resp_err_q;
    assign rx_count      = rx_q;
    assign err_count     = err_q;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign s_axis_tready = (state_q == S_RECV);

    // The generator is never read back; the read channel is tied off.
    assign m_axi_araddr  = '0;
    assign m_axi_arvalid = 1'b0;
    assign m_axi_rready  = 1'b1;

    logic unused_rd;
    assign unused_rd = ^{m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid};

endmodule

// File: tb/tb_lfsr_stream_checker.sv
// Bench for lfsr_stream_checker: randomized AXI-Lite slave and stream source,
// results compared against a behavioural LFSR reference.
module tb_lfsr_stream_checker;

    logic        aclk;
    logic        areset;
    logic        cfg_start;
    logic [7:0]  cfg_seed;
    logic [7:0]  cfg_taps;
    logic [15:0] cfg_count;
    logic        busy, done, pass, resp_err;
    logic [15:0] rx_count, err_count;
    logic [3:0]  m_axi_awaddr;
    logic        m_axi_awvalid, m_axi_awready;
    logic [31:0] m_axi_wdata;
    logic        m_axi_wvalid, m_axi_wready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid, m_axi_bready;
    logic [3:0]  m_axi_araddr;
    logic        m_axi_arvalid, m_axi_arready;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rvalid, m_axi_rready;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid, s_axis_tready;

    lfsr_stream_checker #(
        .C_AXIL_ADDR_WIDTH(4),
        .C_AXIL_DATA_WIDTH(32),
        .C_CNT_WIDTH(16)
    ) dut (
        .aclk(aclk), .areset(areset),
        .cfg_start(cfg_start), .cfg_seed(cfg_seed), .cfg_taps(cfg_taps), .cfg_count(cfg_count),
        .busy(busy), .done(done), .pass(pass), .resp_err(resp_err),
        .rx_count(rx_count), .err_count(err_count),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    int errors = 0;
    int checks = 0;

    logic [31:0] beats[$];
    logic [3:0]  log_a[$];
    logic [31:0] log_d[$];
    int          rdy_pct  = 100;
    int          inj_idx  = -1;
    int          hold_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_step(input logic [7:0] x, input logic [7:0] t);
        int ones;
        ones = $countones(x & t);
        return ((ones % 2) == 1 ? 8'h80 : 8'h00) | (x >> 1);
    endfunction

    function automatic int ref_errs(input logic [7:0] t);
        int n = 0;
        for (int i = 1; i < beats.size(); i++) begin
            logic [7:0] p;
            p = beats[i-1][7:0];
            if (beats[i] !== {24'h0, ref_step(p, t)}) n++;
        end
        return n;
    endfunction

    task automatic build_stream(input logic [7:0] start, input logic [7:0] t, input int n);
        logic [7:0] x;
        beats.delete();
        x = start;
        for (int i = 0; i < n; i++) begin
            beats.push_back({24'h0, x});
            x = ref_step(x, t);
        end
    endtask

    // AXI-Lite write slave with random ready timing and per-test bresp injection.
    initial begin
        bit          aw_have, w_have, aw_pend, w_pend, b_fire;
        logic [3:0]  a, pa;
        logic [31:0] d, pd;
        int          b_wait;
        aw_have = 0; w_have = 0; aw_pend = 0; w_pend = 0; b_fire = 0; b_wait = 0;
        a = '0; pa = '0; d = '0; pd = '0;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0;
        m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
        m_axi_arready = 1'b0; m_axi_rdata = '0; m_axi_rresp = 2'b00; m_axi_rvalid = 1'b0;
        forever begin
            @(negedge aclk);
            if (areset) begin
                aw_have = 0; w_have = 0; aw_pend = 0; w_pend = 0; b_fire = 0; b_wait = 0;
                m_axi_awready = 1'b0; m_axi_wready = 1'b0;
                m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
                continue;
            end
            if (b_fire) begin
                log_a.push_back(a);
                log_d.push_back(d);
                aw_have = 0; w_have = 0; b_fire = 0;
                m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
                b_wait = $urandom_range(0, 1);
            end
            if (aw_pend && (!m_axi_awvalid || m_axi_awaddr !== pa)) hold_err++;
            if (w_pend && (!m_axi_wvalid || m_axi_wdata !== pd)) hold_err++;
            if (aw_have && m_axi_awvalid) hold_err++;
            if (w_have && m_axi_wvalid) hold_err++;
            if (aw_have && w_have) begin
                if (!m_axi_bvalid) begin
                    if (b_wait > 0) b_wait--;
                    else begin
                        m_axi_bvalid = 1'b1;
                        m_axi_bresp  = (log_a.size() == inj_idx) ? 2'b11 : 2'b00;
                    end
                end
                b_fire = m_axi_bvalid && m_axi_bready;
            end
            m_axi_awready = 1'b0;
            if (m_axi_awvalid && !aw_have) begin
                m_axi_awready = ($urandom_range(0, 99) < rdy_pct);
                if (m_axi_awready) begin aw_have = 1; a = m_axi_awaddr; end
            end
            m_axi_wready = 1'b0;
            if (m_axi_wvalid && !w_have) begin
                m_axi_wready = ($urandom_range(0, 99) < rdy_pct);
                if (m_axi_wready) begin w_have = 1; d = m_axi_wdata; end
            end
            aw_pend = m_axi_awvalid && !aw_have;
            pa      = m_axi_awaddr;
            w_pend  = m_axi_wvalid && !w_have;
            pd      = m_axi_wdata;
        end
    end

    task automatic run_test(input string tag, input logic [7:0] seed, input logic [7:0] taps,
                            input int count, input bit gaps, input int abort_at);
        int          idx;
        bit          s_fire, fired, tready_seen, got_done;
        logic [3:0]  ea[4];
        logic [31:0] ed[4];
        int          exp_err;
        bit          exp_rerr, exp_pass;
        ea = '{4'h8, 4'hC, 4'h0, 4'h4};
        ed = '{{24'h0, seed}, {24'h0, taps}, 32'd1, 32'd1};
        idx = 0; s_fire = 0; tready_seen = 0; got_done = 0;
        hold_err = 0;
        log_a.delete();
        log_d.delete();

        @(negedge aclk);
        cfg_seed = seed; cfg_taps = taps; cfg_count = 16'(count); cfg_start = 1'b1;
        @(negedge aclk);
        cfg_start = 1'b0;
        check_eq({tag, ".busy_rise"}, 32'(busy), 32'd1);

        for (int cyc = 0; cyc < 3000; cyc++) begin
            // A start request mid-test must not disturb the latched configuration.
            cfg_start = (cyc == 4);
            if (cyc == 4) begin
                cfg_seed = ~seed; cfg_taps = ~taps; cfg_count = 16'(count + 3);
            end
            fired = s_fire;
            if (fired) idx++;
            s_fire = 0;
            if (abort_at >= 0 && idx == abort_at) begin
                check_eq({tag, ".rx_before_rst"}, 32'(rx_count), 32'(abort_at));
                #1;
                areset = 1'b1;
                s_axis_tvalid = 1'b0;
                @(negedge aclk);
                #1;
                check_eq({tag, ".rst_busy"}, 32'(busy), 32'd0);
                check_eq({tag, ".rst_tready"}, 32'(s_axis_tready), 32'd0);
                check_eq({tag, ".rst_rx"}, 32'(rx_count), 32'd0);
                check_eq({tag, ".rst_awvalid"}, 32'(m_axi_awvalid), 32'd0);
                check_eq({tag, ".rst_bready"}, 32'(m_axi_bready), 32'd0);
                areset = 1'b0;
                return;
            end
            if (done) begin
                got_done = 1;
                break;
            end
            tready_seen |= s_axis_tready;
            if (idx < beats.size()) begin
                if (fired || !s_axis_tvalid)
                    s_axis_tvalid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
                s_axis_tdata = beats[idx];
            end else begin
                s_axis_tvalid = 1'b0;
            end
            s_fire = s_axis_tvalid && s_axis_tready;
            @(negedge aclk);
        end
        cfg_start = 1'b0;
        s_axis_tvalid = 1'b0;

        if (!got_done) begin
            check_eq({tag, ".timeout"}, 32'd0, 32'd1);
            return;
        end

        exp_err  = ref_errs(taps);
        exp_rerr = (inj_idx >= 0) && (inj_idx < 4);
        exp_pass = (exp_err == 0) && !exp_rerr;
        check_eq({tag, ".busy_done"}, 32'(busy), 32'd0);
        check_eq({tag, ".rx_count"}, 32'(rx_count), 32'(count));
        check_eq({tag, ".err_count"}, 32'(err_count), 32'(exp_err));
        check_eq({tag, ".resp_err"}, 32'(resp_err), 32'(exp_rerr));
        check_eq({tag, ".pass"}, 32'(pass), 32'(exp_pass));
        check_eq({tag, ".tready_seen"}, 32'(tready_seen), 32'(count > 0));

        @(negedge aclk);
        #1;
        check_eq({tag, ".done_pulse"}, 32'(done), 32'd0);
        check_eq({tag, ".pass_hold"}, 32'(pass), 32'(exp_pass));
        check_eq({tag, ".n_writes"}, 32'(log_a.size()), 32'd4);
        if (log_a.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check_eq($sformatf("%s.waddr%0d", tag, i), 32'(log_a[i]), 32'(ea[i]));
                check_eq($sformatf("%s.wdata%0d", tag, i), log_d[i], ed[i]);
            end
        end
        check_eq({tag, ".valid_hold"}, 32'(hold_err), 32'd0);
    endtask

    initial begin
        logic [7:0] rs, rt;
        int         rn;
        areset = 1'b1;
        cfg_start = 1'b0; cfg_seed = '0; cfg_taps = '0; cfg_count = '0;
        s_axis_tdata = '0; s_axis_tvalid = 1'b0;

        repeat (3) @(negedge aclk);
        #1;
        check_eq("rst.busy", 32'(busy), 32'd0);
        check_eq("rst.done", 32'(done), 32'd0);
        check_eq("rst.pass", 32'(pass), 32'd0);
        check_eq("rst.resp_err", 32'(resp_err), 32'd0);
        check_eq("rst.rx_count", 32'(rx_count), 32'd0);
        check_eq("rst.err_count", 32'(err_count), 32'd0);
        check_eq("rst.awvalid", 32'(m_axi_awvalid), 32'd0);
        check_eq("rst.wvalid", 32'(m_axi_wvalid), 32'd0);
        check_eq("rst.bready", 32'(m_axi_bready), 32'd0);
        check_eq("rst.tready", 32'(s_axis_tready), 32'd0);
        check_eq("rst.awaddr", 32'(m_axi_awaddr), 32'd0);
        check_eq("rst.wdata", m_axi_wdata, 32'd0);
        check_eq("rst.arvalid", 32'(m_axi_arvalid), 32'd0);
        check_eq("rst.rready", 32'(m_axi_rready), 32'd1);
        areset = 1'b0;

        build_stream(8'h01, 8'h87, 5);
        run_test("basic", 8'h01, 8'h87, 5, 0, -1);

        beats[2] = 32'hC1;
        check_eq("corrupt.model", 32'(ref_errs(8'h87)), 32'd2);
        run_test("corrupt", 8'h01, 8'h87, 5, 0, -1);

        build_stream(8'h01, 8'h87, 5);
        inj_idx = 1;
        run_test("bresp", 8'h01, 8'h87, 5, 0, -1);
        inj_idx = -1;

        beats.delete();
        run_test("zero", 8'h33, 8'h87, 0, 0, -1);

        rdy_pct = 50;
        build_stream(8'h01, 8'h87, 5);
        run_test("gaps_basic", 8'h01, 8'h87, 5, 1, -1);
        beats[2] = 32'hC1;
        run_test("gaps_corrupt", 8'h01, 8'h87, 5, 1, -1);

        for (int t = 0; t < 3; t++) begin
            rs = 8'($urandom);
            rt = 8'($urandom);
            rn = $urandom_range(8, 40);
            build_stream(rs, rt, rn);
            for (int i = 0; i < rn; i++) begin
                if ($urandom_range(0, 9) == 0) beats[i] = beats[i] ^ 32'($urandom_range(1, 255));
                if ($urandom_range(0, 19) == 0) beats[i] = beats[i] | 32'h100;
            end
            run_test($sformatf("rand%0d", t), rs, rt, rn, 1, -1);
        end

        rdy_pct = 100;
        build_stream(8'h5A, 8'hB8, 10);
        run_test("abort", 8'h5A, 8'hB8, 10, 0, 2);
        run_test("after_rst", 8'h5A, 8'hB8, 10, 0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
